// File: rtl/seq_multiplier_32_bit.sv
// Iterative shift-add 32x32->64 multiplier, one adder_32_bit add per cycle over 32 iterations.
// Define MULT_SIGNED_EN for two's-complement operands (adds a sign fixup state, 33-cycle latency).

module adder_32_bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    assign sum = a + b;
endmodule

// state | meaning
// IDLE  | waiting for start, product held
// BUSY  | one shift-add iteration per cycle, 32 in total
// FIXUP | signed build only: apply result sign, then done
module seq_multiplier_32_bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
`ifdef MULT_SIGNED_EN
    localparam logic [1:0] FIXUP = 2'd2;
`endif

    logic [1:0]  state, state_nxt;
    logic [31:0] mcand, acc_hi, acc_lo;
    logic [4:0]  count;
    logic [31:0] add_sum, sum;
    logic        c;
    logic [31:0] op_a, op_b;
`ifdef MULT_SIGNED_EN
    logic        neg;
    // 0x80000000 negates to itself, which is its correct unsigned magnitude
    assign op_a = multiplicand[31] ? (~multiplicand + 32'd1) : multiplicand;
    assign op_b = multiplier[31]   ? (~multiplier + 32'd1)   : multiplier;
`else
    assign op_a = multiplicand;
    assign op_b = multiplier;
`endif

    adder_32_bit u_add (
        .a   (acc_hi),
        .b   (mcand),
        .sum (add_sum)
    );

    assign sum = acc_lo[0] ? add_sum : acc_hi;
    // carry recovered from the MSBs; forced to 0 when no add happens
    assign c   = acc_lo[0] & ((acc_hi[31] & mcand[31]) |
                              ((acc_hi[31] | mcand[31]) & ~sum[31]));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = BUSY;
            BUSY: if (count == 5'd31) begin
`ifdef MULT_SIGNED_EN
                state_nxt = FIXUP;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef MULT_SIGNED_EN
            FIXUP: state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            count   <= '0;
            done    <= 1'b0;
            product <= '0;
`ifdef MULT_SIGNED_EN
            neg     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mcand  <= op_a;
                    acc_hi <= '0;
                    acc_lo <= op_b;
                    count  <= '0;
`ifdef MULT_SIGNED_EN
                    neg    <= multiplicand[31] ^ multiplier[31];
`endif
                end
                BUSY: begin
                    {acc_hi, acc_lo} <= {c, sum, acc_lo[31:1]};
                    count <= count + 5'd1;
`ifndef MULT_SIGNED_EN
                    if (count == 5'd31) begin
                        product <= {c, sum, acc_lo[31:1]};
                        done    <= 1'b1;
                    end
`endif
                end
`ifdef MULT_SIGNED_EN
                FIXUP: begin
                    product <= neg ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
                    done    <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_multiplier_32_bit.sv
// Scoreboard bench for seq_multiplier_32_bit: expected products queued at start, checked at done.
// Follows MULT_SIGNED_EN for latency and operand interpretation.

module tb_seq_multiplier_32_bit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand, multiplier;
    logic        busy, done;
    logic [63:0] product;

`ifdef MULT_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    typedef struct {
        logic [63:0] p;
        int          t0;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;
    logic [63:0] last_exp = '0;

    seq_multiplier_32_bit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (prev_done) chk("done_pulse_width", 64'd2, 64'd1);
            if (sb_q.size() == 0) begin
                chk("spurious_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("product", product, e.p);
                chk("latency", 64'(cyc - e.t0), 64'(LAT));
                chk("busy_at_done", {63'b0, busy}, 64'd0);
                last_exp = e.p;
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b);
        int t;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        t            = cyc + 1;
        @(posedge clk);
        sb_q.push_back('{model(a, b), t});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("timeout", 64'd0, 64'd1);
        repeat (3) @(negedge clk);
        chk("product_held", product, last_exp);
        chk("done_low_after", {63'b0, done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          dc, n;
        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_product", product, 64'd0);
        reset = 1'b0;

        do_op(32'd3, 32'd5);
        chk("busy_mid", {63'b0, busy}, 64'd1);
        wait_done();
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
        do_op(32'h8000_0000, 32'd2);         wait_done();
        do_op(32'd0, 32'hDEAD_BEEF);         wait_done();
        do_op(32'hFFFF_FFFD, 32'd5);         wait_done();
        do_op(32'hFFFF_FFFC, 32'hFFFF_FFFA); wait_done();
        do_op(32'd0, 32'hFFFF_FFFF);         wait_done();
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_op(ra, rb);
            wait_done();
        end

        // protocol: ignored start while busy, then back-to-back start in done cycle
        do_op(32'd7, 32'd9);
        repeat (9) @(negedge clk);
        multiplicand = 32'd100;
        multiplier   = 32'd100;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignored_start", {63'b0, busy}, 64'd1);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("timeout_b2b", 64'd0, 64'd1);
        multiplicand = 32'd2;
        multiplier   = 32'd4;
        start = 1'b1;
        n = cyc + 1;
        @(posedge clk);
        sb_q.push_back('{model(32'd2, 32'd4), n});
        @(negedge clk);
        start = 1'b0;
        chk("busy_b2b", {63'b0, busy}, 64'd1);
        wait_done();
        chk("b2b_product", product, 64'd8);

        // reset mid-operation discards the partial result
        do_op(32'h1234, 32'h5678);
        repeat (13) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_busy", {63'b0, busy}, 64'd0);
        chk("midreset_done", {63'b0, done}, 64'd0);
        chk("midreset_product", product, 64'd0);
        dc = done_cnt;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset", 64'(done_cnt), 64'(dc));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
